// File: rtl/cache_miss_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_miss_ctrl : true-LRU replacement and miss sequencer (wb, refill,   |
// |                   install) for a set-associative cache.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module cache_miss_ctrl #(
  parameter int NUM_SETS      = 64,
  parameter int ASSOCIATIVITY = 4,
  parameter int TAG_WID       = 20,
  parameter int IDX_WID       = $clog2(NUM_SETS),
  parameter int WAY_WID       = $clog2(ASSOCIATIVITY)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       lookup_valid_i,
  input  logic                       hit_i,
  input  logic [WAY_WID-1:0]         hit_way_i,
  input  logic [IDX_WID-1:0]         idx_i,
  input  logic [TAG_WID-1:0]         tag_i,
  input  logic [ASSOCIATIVITY-1:0]   set_valid_i,
  input  logic [ASSOCIATIVITY-1:0]   set_dirty_i,
  input  logic [TAG_WID-1:0]         victim_tag_i,
  output logic                       busy_o,
  output logic [WAY_WID-1:0]         victim_way_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic                       mem_req_we_o,
  output logic [TAG_WID+IDX_WID-1:0] mem_req_addr_o,
  input  logic                       mem_resp_valid_i,
  output logic                       fill_en_o,
  output logic [IDX_WID-1:0]         fill_idx_o,
  output logic [TAG_WID-1:0]         fill_tag_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_REQ  = 3'd1,
    S_WB_WAIT = 3'd2,
    S_RF_REQ  = 3'd3,
    S_RF_WAIT = 3'd4,
    S_FILL    = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WAY_WID-1:0]   r_age [NUM_SETS][ASSOCIATIVITY];
  logic [IDX_WID-1:0]   r_idx;
  logic [TAG_WID-1:0]   r_tag;
  logic [WAY_WID-1:0]   r_victim;

  logic                 w_miss;
  logic                 w_any_invalid;
  logic [WAY_WID-1:0]   w_inv_way;
  logic [WAY_WID-1:0]   w_lru_way;
  logic [WAY_WID-1:0]   w_victim;
  logic                 w_victim_dirty;
  logic                 w_upd_en;
  logic [IDX_WID-1:0]   w_upd_set;
  logic [WAY_WID-1:0]   w_upd_way;
  logic [WAY_WID-1:0]   w_upd_age;

  assign w_miss        = (r_state == S_IDLE) && lookup_valid_i && !hit_i;
  assign w_any_invalid = ~&set_valid_i;

  // Descending scan so the lowest-numbered candidate is the last one written.
  always_comb begin
    w_inv_way = '0;
    w_lru_way = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!set_valid_i[w]) w_inv_way = WAY_WID'(w);
      if (r_age[idx_i][w] == WAY_WID'(ASSOCIATIVITY - 1)) w_lru_way = WAY_WID'(w);
    end
  end

  assign w_victim       = w_any_invalid ? w_inv_way : w_lru_way;
  assign w_victim_dirty = set_valid_i[w_victim] & set_dirty_i[w_victim];

  // One age-update port: hits only occur in IDLE, installs only in FILL.
  assign w_upd_en  = ((r_state == S_IDLE) && lookup_valid_i && hit_i) || (r_state == S_FILL);
  assign w_upd_set = (r_state == S_FILL) ? r_idx    : idx_i;
  assign w_upd_way = (r_state == S_FILL) ? r_victim : hit_way_i;
  assign w_upd_age = r_age[w_upd_set][w_upd_way];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          r_age[s][w] <= WAY_WID'(w);
        end
      end
    end else if (w_upd_en) begin
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
        if (WAY_WID'(w) == w_upd_way) begin
          r_age[w_upd_set][w] <= '0;
        end else if (r_age[w_upd_set][w] < w_upd_age) begin
          r_age[w_upd_set][w] <= r_age[w_upd_set][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_tag    <= '0;
      r_victim <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss) begin
        r_idx    <= idx_i;
        r_tag    <= tag_i;
        r_victim <= w_victim;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    fill_en_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) w_state_nxt = w_victim_dirty ? S_WB_REQ : S_RF_REQ;
      end
      S_WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {victim_tag_i, r_idx};
        if (mem_req_ready_i) w_state_nxt = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (mem_resp_valid_i) w_state_nxt = S_RF_REQ;
      end
      S_RF_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {r_tag, r_idx};
        if (mem_req_ready_i) w_state_nxt = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        if (mem_resp_valid_i) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        fill_en_o   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy_o       = (r_state != S_IDLE);
  assign victim_way_o = r_victim;
  assign fill_idx_o   = r_idx;
  assign fill_tag_o   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_miss_ctrl : randomized scoreboard bench with timestamp-LRU      |
// |                      reference model.  Rev 1.0                           |
// +--------------------------------------------------------------------------+
module tb_cache_miss_ctrl;
  localparam int NS = 64;
  localparam int NW = 4;
  localparam int TW = 20;
  localparam int IW = 6;
  localparam int WW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            rst_n;
  logic            lookup_valid, hit;
  logic [WW-1:0]   hit_way;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tag;
  logic [NW-1:0]   set_valid, set_dirty;
  logic [TW-1:0]   victim_tag;
  logic            busy;
  logic [WW-1:0]   victim_way;
  logic            mem_req_valid, mem_req_ready, mem_req_we;
  logic [TW+IW-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic            fill_en;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;

  cache_miss_ctrl #(.NUM_SETS(NS), .ASSOCIATIVITY(NW), .TAG_WID(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .lookup_valid_i(lookup_valid), .hit_i(hit),
    .hit_way_i(hit_way), .idx_i(idx), .tag_i(tag), .set_valid_i(set_valid),
    .set_dirty_i(set_dirty), .victim_tag_i(victim_tag), .busy_o(busy),
    .victim_way_o(victim_way), .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready), .mem_req_we_o(mem_req_we),
    .mem_req_addr_o(mem_req_addr), .mem_resp_valid_i(mem_resp_valid),
    .fill_en_o(fill_en), .fill_idx_o(fill_idx), .fill_tag_o(fill_tag));

  // Two-way instance for the associativity=2 scenario
  logic            rst2_n, lv2, hit2, mrr2, mresp2;
  logic [0:0]      hw2, vw2;
  logic [IW-1:0]   idx2, fidx2;
  logic [TW-1:0]   tag2, vt2, ftag2;
  logic [1:0]      sv2, sd2;
  logic            busy2, mrv2, mwe2, fe2;
  logic [TW+IW-1:0] maddr2;

  cache_miss_ctrl #(.NUM_SETS(NS), .ASSOCIATIVITY(2), .TAG_WID(TW)) dut2 (
    .clk_i(clk), .rst_ni(rst2_n), .lookup_valid_i(lv2), .hit_i(hit2),
    .hit_way_i(hw2), .idx_i(idx2), .tag_i(tag2), .set_valid_i(sv2),
    .set_dirty_i(sd2), .victim_tag_i(vt2), .busy_o(busy2),
    .victim_way_o(vw2), .mem_req_valid_o(mrv2), .mem_req_ready_i(mrr2),
    .mem_req_we_o(mwe2), .mem_req_addr_o(maddr2), .mem_resp_valid_i(mresp2),
    .fill_en_o(fe2), .fill_idx_o(fidx2), .fill_tag_o(ftag2));

  int checks = 0;
  int failures = 0;

  // Cache arrays (external datapath) and the LRU reference: last-use timestamps
  logic [TW-1:0] m_tag   [NS][NW];
  logic          m_valid [NS][NW];
  logic          m_dirty [NS][NW];
  int            stamp   [NS][NW];
  int            now_t;
  logic [IW-1:0] cur_idx = '0;

  logic [TW+IW:0]       exp_req  [$];
  logic [IW+TW+WW-1:0]  exp_fill [$];

  bit zero_wait, hold_resp, abort;
  int stall_until = 0;

  always_comb victim_tag = m_tag[cur_idx][victim_way];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    lookup_valid = 1'b0; hit = 1'b0; hit_way = '0; idx = '0; tag = '0;
    set_valid = '0; set_dirty = '0;
  endtask

  function automatic logic [NW-1:0] vmask(input int s);
    logic [NW-1:0] m;
    for (int w = 0; w < NW; w++) m[w] = m_valid[s][w];
    return m;
  endfunction

  function automatic logic [NW-1:0] dmask(input int s);
    logic [NW-1:0] m;
    for (int w = 0; w < NW; w++) m[w] = m_dirty[s][w];
    return m;
  endfunction

  task automatic junk(input logic [IW-1:0] s);
    lookup_valid = 1'($urandom_range(0, 1));
    hit          = 1'($urandom_range(0, 1));
    hit_way      = WW'($urandom_range(0, NW - 1));
    idx          = ($urandom_range(0, 1) == 1) ? s : IW'($urandom_range(0, NS - 1));
    tag          = TW'($urandom);
    set_valid    = NW'($urandom);
    set_dirty    = NW'($urandom);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_in;
    exp_req.delete();
    exp_fill.delete();
    step;
    chk("rst_outputs", 64'({busy, mem_req_valid, mem_req_we, mem_req_addr,
                            fill_en, fill_idx, fill_tag, victim_way}), 64'(0));
    rst_n = 1'b1;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) stamp[s][w] = -w;
    now_t = 0;
  endtask

  task automatic do_hit(input int s, input int w, input bit may_dirty);
    lookup_valid = 1'b1; hit = 1'b1; hit_way = WW'(w); idx = IW'(s);
    tag = m_tag[s][w]; set_valid = vmask(s); set_dirty = dmask(s);
    step;
    idle_in;
    now_t++;
    stamp[s][w] = now_t;
    if (may_dirty && $urandom_range(0, 1) == 1) m_dirty[s][w] = 1'b1;
  endtask

  task automatic do_miss(input int s, input logic [TW-1:0] t, input bit lat_chk);
    int v, cyc_n, lat;
    bit d;
    v = -1;
    for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = 0;
      for (int w = 1; w < NW; w++) if (stamp[s][w] < stamp[s][v]) v = w;
    end
    d = m_valid[s][v] && m_dirty[s][v];
    if (d) exp_req.push_back({1'b1, m_tag[s][v], IW'(s)});
    exp_req.push_back({1'b0, t, IW'(s)});
    exp_fill.push_back({IW'(s), t, WW'(v)});
    cur_idx = IW'(s);
    lookup_valid = 1'b1; hit = 1'b0; idx = IW'(s); tag = t;
    hit_way = WW'($urandom_range(0, NW - 1));
    set_valid = vmask(s); set_dirty = dmask(s);
    step;
    idle_in;
    chk("busy_rise", 64'(busy), 64'(1));
    cyc_n = 1;
    lat = -1;
    while (busy && cyc_n < 400) begin
      if (!lat_chk) junk(IW'(s));
      step;
      cyc_n++;
      if (fill_en && lat < 0) lat = cyc_n;
    end
    idle_in;
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL miss_timeout: busy=%0d after %0d cycles, required 0", busy, cyc_n);
      abort = 1'b1;
    end
    if (lat_chk) begin
      chk("fill_latency", 64'(lat), 64'(3));
      chk("busy_drop", 64'(cyc_n - lat), 64'(1));
    end
    m_valid[s][v] = 1'b1;
    m_dirty[s][v] = 1'b0;
    m_tag[s][v]   = t;
    now_t++;
    stamp[s][v] = now_t;
  endtask

  task automatic run_assoc2;
    int last, n;
    last = 0;
    rst2_n = 1'b0; lv2 = 1'b0; hit2 = 1'b0; hw2 = '0; idx2 = '0; tag2 = '0;
    sv2 = 2'b11; sd2 = 2'b00; vt2 = '0; mrr2 = 1'b0; mresp2 = 1'b0;
    step;
    step;
    rst2_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < ((r == 0) ? 4 : 2); k++) begin
        last = (r == 0) ? (k % 2) : ((k + 1) % 2);
        lv2 = 1'b1; hit2 = 1'b1; hw2 = 1'(last);
        step;
      end
      hit2 = 1'b0; tag2 = TW'(r + 1);
      step;
      lv2 = 1'b0;
      chk("a2_busy", 64'(busy2), 64'(1));
      chk("a2_victim", 64'(vw2), 64'(1 - last));
      mrr2 = 1'b1; mresp2 = 1'b1; n = 0;
      while (!fe2 && n < 20) begin
        step;
        n++;
      end
      chk("a2_fill", 64'({fe2, ftag2, vw2}), 64'({1'b1, TW'(r + 1), 1'(1 - last)}));
      mrr2 = 1'b0; mresp2 = 1'b0;
      step;
    end
  endtask

  // Memory responder: ready/response timing, plus stray responses while a request stalls
  initial begin
    bit hs, stall, outst;
    int dly;
    outst = 1'b0; dly = 0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    forever begin
      @(negedge clk);
      hs    = rst_n && mem_req_valid && mem_req_ready;
      stall = rst_n && mem_req_valid && !mem_req_ready;
      @(posedge clk);
      #2;
      mem_resp_valid = 1'b0;
      if (hs) begin
        outst = 1'b1;
        dly   = zero_wait ? 0 : int'($urandom_range(0, 3));
      end
      if (!rst_n) outst = 1'b0;
      else if (outst && !hold_resp) begin
        if (dly == 0) begin
          mem_resp_valid = 1'b1;
          outst = 1'b0;
        end else dly--;
      end else if (stall && !zero_wait && $urandom_range(0, 3) == 0) mem_resp_valid = 1'b1;
      if (cyc < stall_until) mem_req_ready = 1'b0;
      else mem_req_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops expected requests/fills as the DUT presents them
  initial begin
    bit p_stall, p_fill, p_busy;
    logic [TW+IW:0] p_req, e_req;
    logic [IW+TW+WW-1:0] e_fill;
    logic [WW-1:0] p_vic;
    p_stall = 1'b0; p_fill = 1'b0; p_busy = 1'b0; p_req = '0; p_vic = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_stall = 1'b0; p_fill = 1'b0; p_busy = 1'b0;
      end else begin
        if (p_stall) chk("req_hold", 64'({mem_req_valid, mem_req_we, mem_req_addr}), 64'({1'b1, p_req}));
        if (p_busy && busy) chk("victim_stable", 64'(victim_way), 64'(p_vic));
        if (mem_req_valid && mem_req_ready) begin
          if (exp_req.size() == 0) begin
            checks++; failures++;
            $display("FAIL mem_req: unexpected request we=%0d addr=%0h, required none", mem_req_we, mem_req_addr);
          end else begin
            e_req = exp_req.pop_front();
            chk("mem_req", 64'({mem_req_we, mem_req_addr}), 64'(e_req));
          end
        end
        if (fill_en) begin
          chk("fill_one_cycle", 64'(p_fill), 64'(0));
          if (exp_fill.size() == 0) begin
            checks++; failures++;
            $display("FAIL fill: unexpected fill idx=%0h tag=%0h, required none", fill_idx, fill_tag);
          end else begin
            e_fill = exp_fill.pop_front();
            chk("fill", 64'({fill_idx, fill_tag, victim_way}), 64'(e_fill));
          end
        end
        p_stall = mem_req_valid && !mem_req_ready;
        p_req   = {mem_req_we, mem_req_addr};
        p_fill  = fill_en;
        p_busy  = busy;
        p_vic   = victim_way;
      end
    end
  end

  initial begin
    int s, nv;
    int vw [NW];
    abort = 1'b0; zero_wait = 1'b1; hold_resp = 1'b0; rst_n = 1'b0;
    idle_in;
    for (int i = 0; i < NS; i++)
      for (int w = 0; w < NW; w++) begin
        m_valid[i][w] = 1'b0; m_dirty[i][w] = 1'b0; m_tag[i][w] = '0; stamp[i][w] = -w;
      end
    now_t = 0;

    run_assoc2;
    do_reset;
    do_miss(5, 20'h00ABC, 1'b1);

    for (int w = 0; w < NW; w++) begin
      m_valid[3][w] = 1'b1; m_dirty[3][w] = 1'b0; m_tag[3][w] = TW'($urandom);
    end
    do_hit(3, 3, 1'b0);
    do_hit(3, 1, 1'b0);
    do_hit(3, 0, 1'b0);
    do_miss(3, 20'h00055, 1'b0);
    for (int k = 0; k < 3; k++) do_miss(3, TW'($urandom), 1'b0);

    for (int w = 0; w < NW; w++) begin
      m_valid[7][w] = 1'b1; m_dirty[7][w] = 1'b0; m_tag[7][w] = TW'(w + 1);
    end
    m_tag[7][3] = 20'h12345;
    m_dirty[7][3] = 1'b1;
    do_miss(7, 20'h00001, 1'b0);

    stall_until = cyc + 7;
    do_miss(9, 20'h0BEEF, 1'b0);

    // Abandon a miss while waiting for refill data
    hold_resp = 1'b1;
    exp_req.push_back({1'b0, 20'h0F00D, IW'(11)});
    cur_idx = IW'(11);
    lookup_valid = 1'b1; hit = 1'b0; idx = IW'(11); tag = 20'h0F00D;
    set_valid = vmask(11); set_dirty = dmask(11);
    step;
    idle_in;
    step;
    step;
    chk("rf_wait_state", 64'({busy, mem_req_valid, fill_en}), 64'({1'b1, 1'b0, 1'b0}));
    do_reset;
    hold_resp = 1'b0;
    do_miss(3, 20'h00077, 1'b0);

    zero_wait = 1'b0;
    for (int i = 0; i < 400 && !abort; i++) begin
      repeat ($urandom_range(0, 2)) step;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(0, 7));
      nv = 0;
      for (int w = 0; w < NW; w++) if (m_valid[s][w]) begin vw[nv] = w; nv++; end
      if (nv > 0 && $urandom_range(0, 9) < 6) do_hit(s, vw[$urandom_range(0, nv - 1)], 1'b1);
      else do_miss(s, TW'($urandom), 1'b0);
    end

    repeat (5) step;
    chk("req_queue_empty", 64'(exp_req.size()), 64'(0));
    chk("fill_queue_empty", 64'(exp_fill.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Miss-handling and replacement controller for the set-associative cache. It keeps true-LRU age state per set and updates it on every hit and fill. On a miss it picks a victim way, writes the victim back to memory if it is dirty, requests the refill line, then commands the datapath to install the line. The cache tag/data arrays and the memory port are external; this block only sequences them and stalls the pipeline while a miss is outstanding.

Parameters:
num_sets, 64, number of sets; power of 2, ≥2
associativity, 4, ways per set; power of 2, 2..8
tag_wid, 20, tag width in bits
idx_wid, $clog2(num_sets), derived; set index width
way_wid, $clog2(associativity), derived; way number and age width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
lookup_valid_i  in  1  cache lookup this cycle
hit_i  in  1  lookup hit (qualified by lookup_valid_i)
hit_way_i  in  way_wid  way that hit
idx_i  in  idx_wid  lookup set index
tag_i  in  tag_wid  lookup tag
set_valid_i  in  associativity  valid bits of set idx_i
set_dirty_i  in  associativity  dirty bits of set idx_i
victim_tag_i  in  tag_wid  tag stored in way victim_way_o of the latched set (combinational read by datapath)
busy_o  out  1  miss in progress; pipeline must stall
victim_way_o  out  way_wid  latched victim way
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_we_o  out  1  1 = writeback, 0 = refill read
mem_req_addr_o  out  tag_wid+idx_wid  line address {tag, idx}
mem_resp_valid_i  in  1  writeback complete / refill data present, one cycle
fill_en_o  out  1  one-cycle install strobe: write line, set valid, clear dirty
fill_idx_o  out  idx_wid  set to install
fill_tag_o  out  tag_wid  tag to install

Behaviour:
- Reset, while rst_ni=0 at a clock edge:
  - state = IDLE.
  - All outputs 0.
  - Ages of set s, way w: age[s][w] = w, so each set holds a permutation.
  - Reset mid-miss abandons the transaction; no fill is issued.
- LRU update on an access to way w in set s, applied at the next edge:
  - every way v with age[s][v] < age[s][w] gets age+1;
  - age[s][w] = 0;
  - the permutation is preserved.
- Hits: when state is IDLE and lookup_valid_i & hit_i, update set idx_i with way hit_way_i. Hits are not registered in any other state because the pipeline is stalled.
- Victim selection, combinational in IDLE:
  - if set_valid_i has any zero bit, use the lowest-numbered invalid way;
  - otherwise use the way with age == associativity-1.
- FSM:
  - IDLE: on lookup_valid_i & ~hit_i, latch idx_i, tag_i, the victim way, and dirty = set_valid_i[v] & set_dirty_i[v]. Go to WB_REQ if dirty, else RF_REQ. busy_o rises the cycle after the miss lookup.
  - WB_REQ: mem_req_valid_o=1, we=1, addr={victim_tag_i, latched idx}. Go to WB_WAIT on mem_req_ready_i.
  - WB_WAIT: go to RF_REQ on mem_resp_valid_i.
  - RF_REQ: mem_req_valid_o=1, we=0, addr={latched tag, latched idx}. Go to RF_WAIT on ready.
  - RF_WAIT: go to FILL on mem_resp_valid_i.
  - FILL: fill_en_o=1 for exactly one cycle with latched idx/tag; victim_way_o holds the way. Apply the LRU update (latched set, victim way). Go to IDLE.
- busy_o = (state != IDLE).
- victim_way_o is stable from the cycle after the miss through FILL.
- Request outputs are held stable until ready (valid/ready rule: no retraction).
- If mem_resp_valid_i arrives in a *_REQ state it is ignored.
- If lookup_valid_i is asserted while busy it is ignored.
- Miss latency with zero-wait memory and a clean victim: miss cycle, then RF_REQ, RF_WAIT, FILL, so fill_en_o is asserted 3 cycles after the miss lookup.
- Age arithmetic is modulo-free. Ages never exceed associativity-1 because only ages below the accessed way's age are incremented.

Test Plan:
- Reset then miss on idx=5, tag=0x00ABC, all ways invalid -> victim_way_o=0; mem_req {0x00ABC,5} with we=0; after the response, fill_en_o pulses one cycle and busy_o drops the next cycle.
- Set 3 all valid and clean after reset, hits on ways 3,1,0 then a miss -> victim is way 2 (age 3); ages after the fill are w2=0, w0=1, w1=2, w3=3.
- Miss with victim dirty, victim_tag_i=0x12345, idx=7, new tag 0x00001 -> writeback {0x12345,7} we=1 first, then refill {0x00001,7} we=0. Exactly one fill_en_o.
- mem_req_ready_i held low for 5 cycles in RF_REQ -> mem_req_valid_o and mem_req_addr_o stay constant; hits and lookups presented during that time cause no LRU change.
- Assert rst_ni=0 during RF_WAIT -> next cycle busy_o=0 and fill_en_o=0, and ages return to age[s][w]=w.
- associativity=2: alternate hits on ways 0 and 1 in set 0, then miss -> victim is the way not most recently hit.
